otter_fetch_ctrl: RTL and testbench

Fetch sequencer for the OTTER core: owns the program counter and fetches instructions over a request/acknowledge instruction-memory port. It presents each fetched instruction to the decode/execute side with a valid/ready handshake. It applies control transfers resolved by the PC-source decode, selecting among the JALR, branch, JAL, trap-vector and trap-return targets, and flushes wrong-path work.

---
 rtl/otter_pkg.sv | 33 +++
 rtl/otter_fetch_ctrl_if.sv | 31 +++
 rtl/otter_pc_mux.sv | 39 +++
 rtl/otter_fetch_ctrl.sv | 98 +++++++++
 tb/tb_otter_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the OTTER fetch sequencer.
// Contents:
//   pcsrc_t        PC_SOURCE transfer codes (sequential, JALR, branch, JAL, MTVEC, MEPC)
//   fetch_state_t  fetch sequencer states
//   NOP_INSTR      instruction word held in IR after reset (addi x0,x0,0)
//   PC_INCR        sequential PC step
//   decode_src     maps the raw 3-bit PC_SOURCE code to pcsrc_t; unused codes act as sequential
package otter_pkg;

    typedef enum logic [2:0] {
        PCSRC_SEQ    = 3'd0,
        PCSRC_JALR   = 3'd1,
        PCSRC_BRANCH = 3'd2,
        PCSRC_JAL    = 3'd3,
        PCSRC_MTVEC  = 3'd4,
        PCSRC_MEPC   = 3'd5
    } pcsrc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    function automatic pcsrc_t decode_src(input logic [2:0] code);
        return (code > 3'd5) ? PCSRC_SEQ : pcsrc_t'(code);
    endfunction

endpackage

// File: rtl/otter_fetch_ctrl_if.sv
// otter_fetch_ctrl_if: instruction-memory request/ack bus plus the IR valid/ready handoff.
// Signals:
//   imem_req, imem_addr   fetch request and address (driven by the fetch sequencer)
//   imem_ack, imem_data   request retired and instruction word (driven by memory)
//   ir_valid, ir, ir_pc   fetched instruction and its address (driven by the fetch sequencer)
//   ir_ready              consumer accepts IR this cycle (driven by decode/execute)
// Modports:
//   master  fetch sequencer side
//   slave   memory + consumer side
interface otter_fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc,
        input  imem_ack, imem_data, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc,
        output imem_ack, imem_data, ir_ready
    );

endinterface

// File: rtl/otter_pc_mux.sv
// otter_pc_mux: combinational control-transfer target select with alignment handling.
// Configuration: OTTER_FETCH_MISALIGN_EN
//   defined   - a target with bits [1:0] != 00 is replaced by MTVEC (word-aligned) and flagged
//   undefined - the target is word-aligned by masking; misaligned is always 0
// Ports:
//   src                                          decoded transfer select
//   jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc   candidate targets
//   tgt                                          address to load into pc
//   misaligned                                   selected target was not word-aligned
module otter_pc_mux
    import otter_pkg::*;
(
    input  pcsrc_t      src,
    input  logic [31:0] jalr_tgt,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jal_tgt,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] tgt,
    output logic        misaligned
);

    logic [31:0] raw;

    assign raw = (src == PCSRC_JALR)   ? jalr_tgt   :
                 (src == PCSRC_BRANCH) ? branch_tgt :
                 (src == PCSRC_JAL)    ? jal_tgt    :
                 (src == PCSRC_MTVEC)  ? mtvec      :
                 (src == PCSRC_MEPC)   ? mepc       : 32'h0;

`ifdef OTTER_FETCH_MISALIGN_EN
    assign misaligned = |raw[1:0];
    assign tgt        = misaligned ? (mtvec & ~32'h3) : raw;
`else
    assign misaligned = 1'b0;
    assign tgt        = raw & ~32'h3;
`endif

endmodule

// File: rtl/otter_fetch_ctrl.sv
// otter_fetch_ctrl: OTTER fetch sequencer - owns pc, fetches over a req/ack memory port,
// hands instructions to decode with valid/ready and applies control transfers with flush.
// Configuration: OTTER_FETCH_MISALIGN_EN enables misaligned-target trapping to MTVEC.
// Parameters:
//   RESET_PC     pc value after reset
// Ports:
//   clk, rst_n                                   clock, asynchronous active-low reset
//   pc_source, xfer_valid                        transfer select and its qualifier
//   jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc   transfer targets
//   bus                                          memory request/ack and IR valid/ready (master)
//   flush                                        one-cycle pulse after a redirect
//   misalign                                     one-cycle pulse with flush for a misaligned target
module otter_fetch_ctrl
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                pc_source,
    input  logic                      xfer_valid,
    input  logic [31:0]               jalr_tgt,
    input  logic [31:0]               branch_tgt,
    input  logic [31:0]               jal_tgt,
    input  logic [31:0]               mtvec,
    input  logic [31:0]               mepc,
    otter_fetch_ctrl_if.master        bus,
    output logic                      flush,
    output logic                      misalign
);

    fetch_state_t state, state_nx;
    pcsrc_t       src;
    logic [31:0]  pc, pc_nx, tgt, addr_nx;
    logic         redirect, mis, issue, req_nx, valid_nx, load_ir;

    assign src      = decode_src(pc_source);
    assign redirect = xfer_valid && (src != PCSRC_SEQ);

    otter_pc_mux u_pc_mux (
        .src        (src),
        .jalr_tgt   (jalr_tgt),
        .branch_tgt (branch_tgt),
        .jal_tgt    (jal_tgt),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .tgt        (tgt),
        .misaligned (mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
            bus.ir        <= NOP_INSTR;
            bus.ir_pc     <= 32'h0;
            bus.ir_valid  <= 1'b0;
            flush         <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            state         <= state_nx;
            pc            <= pc_nx;
            bus.imem_req  <= req_nx;
            bus.imem_addr <= addr_nx;
            bus.ir_valid  <= valid_nx;
            flush         <= redirect;
            misalign      <= redirect && mis;
            if (load_ir) begin
                bus.ir    <= bus.imem_data;
                bus.ir_pc <= bus.imem_addr;
            end
        end
    end

    // A redirect in FETCH without a same-cycle ack must let the live request retire in DRAIN.
    always_comb begin
        state_nx = (state == ST_IDLE)  ? ST_FETCH :
                   (state == ST_FETCH) ? (bus.imem_ack ? (redirect ? ST_FETCH : ST_HOLD)
                                                       : (redirect ? ST_DRAIN : ST_FETCH)) :
                   (state == ST_HOLD)  ? ((redirect || bus.ir_ready) ? ST_FETCH : ST_HOLD) :
                                         (bus.imem_ack ? ST_FETCH : ST_DRAIN);
    end

    // Outputs are computed from the next state and registered, so every port is a flop.
    // The address only changes when a fresh request is issued; an outstanding one keeps its address.
    always_comb begin
        pc_nx    = redirect                              ? tgt :
                   (state == ST_HOLD && bus.ir_ready)    ? pc + PC_INCR : pc;
        issue    = (state_nx == ST_FETCH) && !(state == ST_FETCH && !bus.imem_ack);
        req_nx   = (state_nx == ST_FETCH) || (state_nx == ST_DRAIN);
        addr_nx  = issue ? pc_nx : bus.imem_addr;
        valid_nx = (state_nx == ST_HOLD);
        load_ir  = (state == ST_FETCH) && bus.imem_ack && !redirect;
    end

endmodule

// File: tb/tb_otter_fetch_ctrl.sv
// tb_otter_fetch_ctrl: directed scoreboard bench for otter_fetch_ctrl (RESET_PC = 0x100).
// Stimulus pushes expected request addresses, delivered instruction PCs and flush/misalign
// values into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_otter_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  pc_source = 3'b000;
    logic        xfer_valid = 1'b0;
    logic [31:0] jalr_tgt = 32'h0, branch_tgt = 32'h0, jal_tgt = 32'h0;
    logic [31:0] mtvec = 32'h0, mepc = 32'h0;
    logic        flush, misalign;

    otter_fetch_ctrl_if bus();

    otter_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_source  (pc_source),
        .xfer_valid (xfer_valid),
        .jalr_tgt   (jalr_tgt),
        .branch_tgt (branch_tgt),
        .jal_tgt    (jal_tgt),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .bus        (bus),
        .flush      (flush),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

`ifdef OTTER_FETCH_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    int          checks = 0;
    int          fails = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_ir[$];
    logic        exp_flush[$];
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] p;
    logic [31:0] mis_t;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ a ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !bus.ir_valid; i++) cyc();
        if (!bus.ir_valid) begin
            checks++;
            fails++;
            $display("FAIL %s timeout ir_valid=0 exp=1", name);
        end
    endtask

    task automatic take_one(input logic [31:0] pc_e, input logic [31:0] nxt);
        exp_ir.push_back(pc_e);
        exp_addr.push_back(nxt);
        wait_valid("take");
        bus.ir_ready = 1'b1;
        cyc();
        bus.ir_ready = 1'b0;
    endtask

    // Memory model: acks lat cycles after a request starts, one ack per request.
    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !bus.imem_req) begin
                bus.imem_ack = 1'b0;
                cnt = 0;
            end else if (bus.imem_ack) begin
                bus.imem_ack = 1'b0;
                cnt = 1;
            end else if (cnt >= lat) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = mdata(bus.imem_addr);
                cnt = 0;
            end else begin
                cnt++;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (bus.imem_req && !pend) begin
                    if (exp_addr.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL req_unexpected got=%h exp=none", bus.imem_addr);
                    end else begin
                        chk("req_addr", bus.imem_addr, exp_addr.pop_front());
                    end
                    pend  = 1'b1;
                    paddr = bus.imem_addr;
                end else if (pend) begin
                    chk("req_held", {31'h0, bus.imem_req}, 32'h1);
                    chk("addr_held", bus.imem_addr, paddr);
                end
                if (bus.imem_req && bus.imem_ack) pend = 1'b0;
                if (bus.ir_valid && bus.ir_ready) begin
                    if (exp_ir.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL ir_unexpected got=%h exp=none", bus.ir_pc);
                    end else begin
                        p = exp_ir.pop_front();
                        chk("ir_pc", bus.ir_pc, p);
                        chk("ir_data", bus.ir, mdata(p));
                    end
                end
                if (flush) begin
                    if (exp_flush.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL flush_unexpected got=1 exp=0");
                    end else begin
                        chk("misalign", {31'h0, misalign}, {31'h0, exp_flush.pop_front()});
                        chk("flush_ir_valid", {31'h0, bus.ir_valid}, 32'h0);
                    end
                end else if (misalign) begin
                    checks++;
                    fails++;
                    $display("FAIL misalign_without_flush got=1 exp=0");
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bus.ir_ready = 1'b0;
        mis_t = MIS_EN ? 32'h80 : 32'h400;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h100);
        chk("rst_ir", bus.ir, 32'h0000_0013);
        chk("rst_ir_pc", bus.ir_pc, 32'h0);
        chk("rst_valid", {31'h0, bus.ir_valid}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        exp_addr.push_back(32'h100);
        rst_n = 1'b1;
        chk("idle_no_req", {31'h0, bus.imem_req}, 32'h0);
        cyc();
        chk("first_req", {31'h0, bus.imem_req}, 32'h1);
        chk("first_addr", bus.imem_addr, 32'h100);
        take_one(32'h100, 32'h104);
        take_one(32'h104, 32'h108);
        wait_valid("hold_108");
        repeat (5) begin
            chk("stall_ir", bus.ir, mdata(32'h108));
            chk("stall_pc", bus.ir_pc, 32'h108);
            chk("stall_no_req", {31'h0, bus.imem_req}, 32'h0);
            cyc();
        end
        lat = 3;
        take_one(32'h108, 32'h10C);
        chk("next_req", {31'h0, bus.imem_req}, 32'h1);
        chk("next_addr", bus.imem_addr, 32'h10C);
        pc_source  = 3'b010;
        branch_tgt = 32'h300;
        xfer_valid = 1'b1;
        exp_flush.push_back(1'b0);
        exp_addr.push_back(32'h300);
        cyc();
        xfer_valid = 1'b0;
        chk("br_flush", {31'h0, flush}, 32'h1);
        chk("drain_req", {31'h0, bus.imem_req}, 32'h1);
        chk("drain_addr", bus.imem_addr, 32'h10C);
        wait_valid("hold_300");
        chk("hold_300_pc", bus.ir_pc, 32'h300);
        lat = 1;
        pc_source  = 3'b011;
        jal_tgt    = 32'h200;
        xfer_valid = 1'b1;
        exp_flush.push_back(1'b0);
        exp_addr.push_back(32'h200);
        cyc();
        xfer_valid = 1'b0;
        chk("jal_flush", {31'h0, flush}, 32'h1);
        chk("jal_valid", {31'h0, bus.ir_valid}, 32'h0);
        chk("jal_addr", bus.imem_addr, 32'h200);
        take_one(32'h200, 32'h204);
        for (int i = 0; i < 10 && !bus.imem_ack; i++) cyc();
        if (!bus.imem_ack) begin
            checks++;
            fails++;
            $display("FAIL ack_wait timeout got=0 exp=1");
        end
        jal_tgt    = 32'hFFFF_FFFC;
        xfer_valid = 1'b1;
        exp_flush.push_back(1'b0);
        exp_addr.push_back(32'hFFFF_FFFC);
        cyc();
        xfer_valid = 1'b0;
        chk("same_req", {31'h0, bus.imem_req}, 32'h1);
        chk("same_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("same_flush", {31'h0, flush}, 32'h1);
        take_one(32'hFFFF_FFFC, 32'h0);
        take_one(32'h0, 32'h4);
        wait_valid("hold_4");
        pc_source  = 3'b110;
        jal_tgt    = 32'h700;
        xfer_valid = 1'b1;
        cyc();
        xfer_valid = 1'b0;
        chk("seq_no_flush", {31'h0, flush}, 32'h0);
        chk("seq_valid", {31'h0, bus.ir_valid}, 32'h1);
        chk("seq_no_req", {31'h0, bus.imem_req}, 32'h0);
        pc_source  = 3'b001;
        jalr_tgt   = 32'h402;
        mtvec      = 32'h80;
        xfer_valid = 1'b1;
        exp_flush.push_back(MIS_EN);
        exp_addr.push_back(mis_t);
        cyc();
        xfer_valid = 1'b0;
        chk("mis_flush", {31'h0, flush}, 32'h1);
        chk("mis_pulse", {31'h0, misalign}, {31'h0, MIS_EN});
        chk("mis_addr", bus.imem_addr, mis_t);
        take_one(mis_t, mis_t + 32'h4);
        wait_valid("hold_after_mis");
        pc_source  = 3'b101;
        mepc       = 32'h500;
        xfer_valid = 1'b1;
        exp_flush.push_back(1'b0);
        exp_addr.push_back(32'h500);
        cyc();
        xfer_valid = 1'b0;
        chk("mepc_addr", bus.imem_addr, 32'h500);
        chk("mepc_misalign", {31'h0, misalign}, 32'h0);
        take_one(32'h500, 32'h504);
        repeat (6) cyc();
        chk("addr_q_left", exp_addr.size(), 32'h0);
        chk("ir_q_left", exp_ir.size(), 32'h0);
        chk("flush_q_left", exp_flush.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
